// File: rtl/sha256_pkg.sv
// Shared types and widths for the SHA-256 engine array and its memory arbiter.
package sha256_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] mem_addr_t;

  // ARB: port has no owner; OWN: exactly one gnt bit is set
  typedef enum logic [0:0] {
    ARB = 1'b0,
    OWN = 1'b1
  } arb_state_e;
endpackage

// File: rtl/sha256_mem_arbiter_rr_pick.sv
// Rotating-priority encoder: first set req bit at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          any
);

  // Scan from farthest to nearest so the lowest rotated offset wins last
  always_comb begin
    logic [PW-1:0] j;
    j   = '0;
    idx = '0;
    any = |req;
    for (int i = N - 1; i >= 0; i--) begin
      j = PW'((int'(ptr) + i) % N);
      if (req[j]) idx = j;
    end
  end

endmodule

// File: rtl/sha256_mem_arbiter.sv
// Round-robin owner of the shared message/hash memory port with bounded bursts.
// The owner's address/write signals pass straight through; read data is
// broadcast with a registered per-engine valid one cycle after the read.
module sha256_mem_arbiter
  import sha256_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_we,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int PW = $clog2(NUM_REQ);
  // MAX_BURST=0 disables preemption; keep a 1-bit counter so widths stay legal
  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [BW-1:0] LAST = (MAX_BURST > 0) ? BW'(MAX_BURST - 1) : '0;

  arb_state_e    state;
  logic [PW-1:0] owner, rr_ptr, pick;
  logic [BW-1:0] burst_cnt;
  logic          any_req, access, others, preempt, rel;

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .idx (pick),
    .any (any_req)
  );

  // Access / release decode for the current owner
  always_comb begin
    access  = (state == OWN) && req[owner];
    others  = |(req & ~(NUM_REQ'(1) << owner));
    preempt = (MAX_BURST != 0) && (burst_cnt == LAST) && others;
    rel     = (state == OWN) && (!req[owner] || preempt);
  end

  // Owner drives the memory port; idle port is held at zero
  always_comb begin
    mem_we    = access && req_we[owner];
    mem_addr  = access ? req_addr[owner*ADDR_W +: ADDR_W] : '0;
    mem_wdata = access ? req_wdata[owner*DATA_W +: DATA_W] : '0;
    rd_data   = mem_rdata;
  end

  // Ownership FSM: grant, burst counting, release with rotating pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      gnt       <= '0;
    end else begin
      case (state)
        ARB: if (any_req) begin
          state     <= OWN;
          owner     <= pick;
          gnt       <= NUM_REQ'(1) << pick;
          burst_cnt <= '0;
        end
        OWN: if (rel) begin
          state  <= ARB;
          gnt    <= '0;
          rr_ptr <= (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        end else if (MAX_BURST != 0 && burst_cnt != LAST) begin
          burst_cnt <= burst_cnt + 1'b1;
        end
        default: state <= ARB;
      endcase
    end
  end

  // Read-valid pipeline: tags the data returning one cycle after a read access,
  // even when ownership was released on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= '0;
    end else begin
      rd_valid <= '0;
      if (access && !req_we[owner]) rd_valid[owner] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sha256_mem_arbiter.sv
// Directed bench for sha256_mem_arbiter (NUM_REQ=4, MAX_BURST=4) with a
// 1-cycle-latency memory model; memory word i holds 32'hA500_0000 | i.
module tb_sha256_mem_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*16-1:0] req_addr = '0;
  logic [N*32-1:0] req_wdata = '0;
  logic [N-1:0]    gnt, rd_valid;
  logic [31:0]     rd_data, mem_wdata;
  logic [31:0]     mem_rdata = '0;
  logic [15:0]     mem_addr;
  logic            mem_we;
  logic [31:0]     mem [0:255];
  logic            multi_hot = 1'b0;
  int              errors = 0;
  int              checks = 0;

  sha256_mem_arbiter #(.NUM_REQ(N), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:0]];
  end

  always @(negedge clk) begin
    if (!$onehot0(gnt) || !$onehot0(rd_valid)) multi_hot = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic r, input logic we,
                       input logic [15:0] a, input logic [31:0] d);
    req[k]             = r;
    req_we[k]          = we;
    req_addr[k*16+:16] = a;
    req_wdata[k*32+:32] = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;

    // Reset holds everything idle even with a request present
    drive(0, 1'b1, 1'b0, 16'h0000, 32'h0);
    tick(); tick();
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);

    // 1: single engine reads 0..3
    rst = 1'b0;
    tick();
    chk("t1_gnt", 32'(gnt), 32'h1);
    for (int i = 0; i < 4; i++) begin
      req_addr[15:0] = 16'(i);
      #1;
      chk("t1_mem_addr", 32'(mem_addr), 32'(i));
      tick();
      chk("t1_rd_valid", 32'(rd_valid), 32'h1);
      chk("t1_rd_data", rd_data, 32'hA500_0000 | 32'(i));
    end
    req[0] = 1'b0;
    #1;
    chk("t1_gnt_hold", 32'(gnt), 32'h1);
    tick();
    chk("t1_gnt_drop", 32'(gnt), 32'h0);
    chk("t1_rd_valid_end", 32'(rd_valid), 32'h0);

    // 2: all four request from reset, each holds 3 access cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < N; k++) drive(k, 1'b1, 1'b0, 16'h0020 + 16'(k), 32'h0);
    tick();
    for (int k = 0; k < N; k++) begin
      for (int c = 0; c < 3; c++) begin
        #1;
        chk("t2_gnt", 32'(gnt), 32'(1) << k);
        tick();
      end
      req[k] = 1'b0;
      #1;
      chk("t2_gnt_last", 32'(gnt), 32'(1) << k);
      chk("t2_rd_valid", 32'(rd_valid), 32'(1) << k);
      chk("t2_rd_data", rd_data, 32'hA500_0020 + 32'(k));
      chk("t2_no_access", 32'(mem_addr), 32'h0);
      tick();
      chk("t2_idle", 32'(gnt), 32'h0);
      tick();
    end

    // 3: burst limit preempts owner 0 once engine 2 waits
    drive(0, 1'b1, 1'b0, 16'h0030, 32'h0);
    tick();
    drive(2, 1'b1, 1'b0, 16'h0040, 32'h0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t3_gnt0", 32'(gnt), 32'h1);
      tick();
    end
    chk("t3_preempt", 32'(gnt), 32'h0);
    chk("t3_rd_valid", 32'(rd_valid), 32'h1);
    chk("t3_rd_data", rd_data, 32'hA500_0030);
    tick();
    for (int c = 0; c < 2; c++) begin
      chk("t3_gnt2", 32'(gnt), 32'h4);
      tick();
    end
    req[2] = 1'b0;
    tick();
    chk("t3_idle", 32'(gnt), 32'h0);
    tick();
    chk("t3_reserve0", 32'(gnt), 32'h1);

    // 4: owner 1 reads addr 8 on its final (preempted) access
    req[0] = 1'b0;
    drive(1, 1'b1, 1'b0, 16'h0005, 32'h0);
    tick();
    chk("t4_idle", 32'(gnt), 32'h0);
    tick();
    drive(3, 1'b1, 1'b1, 16'h0010, 32'hDEAD_BEEF);
    for (int c = 0; c < 4; c++) begin
      req_addr[31:16] = 16'h0005 + 16'(c);
      #1;
      chk("t4_gnt1", 32'(gnt), 32'h2);
      tick();
    end
    chk("t4_gnt_rel", 32'(gnt), 32'h0);
    chk("t4_rd_valid", 32'(rd_valid), 32'h2);
    chk("t4_rd_data", rd_data, 32'hA500_0008);
    req[1] = 1'b0;
    tick();
    chk("t4_gnt3", 32'(gnt), 32'h8);

    // 5: write by owner 3, then reset mid-burst during a read
    #1;
    chk("t5_mem_we", 32'(mem_we), 32'h1);
    chk("t5_mem_addr", 32'(mem_addr), 32'h0010);
    chk("t5_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    chk("t5_wr_no_rdv", 32'(rd_valid), 32'h0);
    rst = 1'b1;
    drive(3, 1'b1, 1'b0, 16'h0010, 32'h0);
    tick();
    chk("t5_rst_gnt", 32'(gnt), 32'h0);
    chk("t5_rst_rdv", 32'(rd_valid), 32'h0);
    chk("t5_rst_we", 32'(mem_we), 32'h0);
    chk("t5_mem_written", mem[16], 32'hDEAD_BEEF);
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 16'h0000, 32'h0);
    tick();
    chk("t5_restart0", 32'(gnt), 32'h1);
    req = '0;
    tick();
    chk("t5_drop", 32'(gnt), 32'h0);

    // 6: a non-owner driving write enable is ignored
    drive(2, 1'b0, 1'b1, 16'h0011, 32'h1234_5678);
    #1;
    chk("t6_idle_we", 32'(mem_we), 32'h0);
    drive(0, 1'b1, 1'b0, 16'h0011, 32'h0);
    tick();
    #1;
    chk("t6_gnt0", 32'(gnt), 32'h1);
    chk("t6_own_we", 32'(mem_we), 32'h0);
    chk("t6_own_addr", 32'(mem_addr), 32'h0011);
    chk("t6_own_wdata", mem_wdata, 32'h0);
    tick();
    chk("t6_rd_valid", 32'(rd_valid), 32'h1);
    chk("t6_rd_data", rd_data, 32'hA500_0011);
    req = '0;
    tick();
    chk("t6_mem_kept", mem[17], 32'hA500_0011);
    chk("t6_gnt_end", 32'(gnt), 32'h0);

    chk("onehot_gnt_rdv", 32'(multi_hot), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
